reset_sequencer: RTL and testbench

//  Successor to the single-output reset synchroniser. Sits between the board

---
 rtl/reset_sequencer_pkg.sv | 18 +
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/reset_sequencer_sync_cell.sv | 22 ++
 rtl/reset_sequencer.sv | 138 +++++++++++++
 tb/tb_reset_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types for the staggered reset sequencer: FSM states and reset causes.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'b00,
    HOLD    = 2'b01,
    RELEASE = 2'b10,
    RUN     = 2'b11
  } rs_state_t;

  // Encoding is visible on reset_cause; 2'b11 stays reserved.
  typedef enum logic [1:0] {
    CAUSE_PIN = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } rs_cause_t;

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer. The master side drives the
// software reset request and the watchdog controls. The slave side (the
// sequencer) returns the per-domain resets, the reset cause and busy.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   sw_reset_req;
  logic                   wdt_en;
  logic                   wdt_kick;
  logic [NUM_DOMAINS-1:0] resetn_out;
  logic [1:0]             reset_cause;
  logic                   busy;

  modport master (
    output sw_reset_req, wdt_en, wdt_kick,
    input  resetn_out, reset_cause, busy
  );

  modport slave (
    input  sw_reset_req, wdt_en, wdt_kick,
    output resetn_out, reset_cause, busy
  );
endinterface

// File: rtl/reset_sequencer_sync_cell.sv
// Reset synchroniser for the board pin. Assertion is asynchronous. Release
// ripples through STAGES flops, so downstream logic sees a clean,
// clock-aligned deassertion.
module reset_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [STAGES-1:0] r_chain;

  // Shift ones in after release; clear the whole chain at once on assertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], 1'b1};
  end

  assign o_rst_n = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset sequencer. Domain 0 is released first and
// each later domain follows STAGGER_CYCLES after the previous one. Also
// handles software reset requests, a watchdog and a sticky reset cause.
//
// state   | meaning
// SYNC    | waiting for the synchronised pin release
// HOLD    | all domains held low for HOLD_CYCLES
// RELEASE | domains released one by one
// RUN     | all domains out of reset, watchdog active
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int WDT_TIMEOUT    = 2**20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  reset_sequencer_if.slave   bus
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STG_MAX = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int STG_W   = (STG_MAX > 0) ? $clog2(STG_MAX + 1) : 1;
  localparam int WDT_W   = $clog2(WDT_TIMEOUT + 1);

  logic                   w_sync_rst_n;
  rs_state_t              r_state,    w_state_nxt;
  logic [HOLD_W-1:0]      r_hold_cnt, w_hold_nxt;
  logic [STG_W-1:0]       r_stg_cnt,  w_stg_nxt;
  logic [WDT_W-1:0]       r_wdt_cnt,  w_wdt_nxt;
  logic [NUM_DOMAINS-1:0] r_resetn,   w_resetn_nxt;
  rs_cause_t              r_cause,    w_cause_nxt;
  logic                   r_busy;
  logic                   w_int_rst;

  reset_sync_cell #(.STAGES(SYNC_STAGES)) u_pin_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .o_rst_n (w_sync_rst_n)
  );

  // Next-state, counters, outputs and cause; every target defaults to hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_stg_nxt    = r_stg_cnt;
    w_wdt_nxt    = r_wdt_cnt;
    w_resetn_nxt = r_resetn;
    w_cause_nxt  = r_cause;
    w_int_rst    = 1'b0;

    case (r_state)
      SYNC: begin
        if (w_sync_rst_n) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
      end

      HOLD: begin
        if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt     = RELEASE;
          w_stg_nxt       = '0;
          w_resetn_nxt[0] = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (r_stg_cnt != STG_W'(STG_MAX))
          w_stg_nxt = r_stg_cnt + STG_W'(1);
        for (int i = 1; i < NUM_DOMAINS; i++) begin
          if (int'(w_stg_nxt) >= i * STAGGER_CYCLES)
            w_resetn_nxt[i] = 1'b1;
        end
        // With a single domain everything is already out, so RELEASE
        // lasts exactly one cycle.
        if (&w_resetn_nxt)
          w_state_nxt = RUN;
      end

      RUN: begin
        if (bus.sw_reset_req) begin
          w_int_rst   = 1'b1;
          w_cause_nxt = CAUSE_SW;
        end else if (bus.wdt_kick) begin
          w_wdt_nxt = '0;
        end else if (bus.wdt_en) begin
          if (r_wdt_cnt == WDT_W'(WDT_TIMEOUT - 1)) begin
            w_int_rst   = 1'b1;
            w_cause_nxt = CAUSE_WDT;
          end else begin
            w_wdt_nxt = r_wdt_cnt + WDT_W'(1);
          end
        end
        if (w_int_rst) begin
          w_state_nxt  = HOLD;
          w_hold_nxt   = '0;
          w_stg_nxt    = '0;
          w_wdt_nxt    = '0;
          w_resetn_nxt = '0;
        end
      end

      default: w_state_nxt = SYNC;
    endcase
  end

  // State and output registers; the pin forces the full restart condition.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= SYNC;
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
      r_wdt_cnt  <= '0;
      r_resetn   <= '0;
      r_cause    <= CAUSE_PIN;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_stg_cnt  <= w_stg_nxt;
      r_wdt_cnt  <= w_wdt_nxt;
      r_resetn   <= w_resetn_nxt;
      r_cause    <= w_cause_nxt;
      r_busy     <= ~&w_resetn_nxt;
    end
  end

  assign bus.resetn_out  = r_resetn;
  assign bus.reset_cause = r_cause;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: main instance 2/3/16/8 with a 64-cycle watchdog,
// plus two instances with other parameters (1 domain with stagger 1, and
// 4 domains with hold 1).
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] rn;
    logic       busy;
    logic [1:0] cause;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_a;
  logic rst_bc;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];
  logic [2:0] last_rn;
  logic       last_busy;
  logic [1:0] last_cause;
  bit         kick_done;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  reset_sequencer_if #(.NUM_DOMAINS(3)) if_a ();
  reset_sequencer_if #(.NUM_DOMAINS(1)) if_b ();
  reset_sequencer_if #(.NUM_DOMAINS(4)) if_c ();

  reset_sequencer #(.SYNC_STAGES(2), .NUM_DOMAINS(3), .HOLD_CYCLES(16),
                    .STAGGER_CYCLES(8), .WDT_TIMEOUT(64)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(rst_a), .bus(if_a.slave));
  reset_sequencer #(.SYNC_STAGES(2), .NUM_DOMAINS(1), .HOLD_CYCLES(16),
                    .STAGGER_CYCLES(1), .WDT_TIMEOUT(64)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(rst_bc), .bus(if_b.slave));
  reset_sequencer #(.SYNC_STAGES(2), .NUM_DOMAINS(4), .HOLD_CYCLES(1),
                    .STAGGER_CYCLES(8), .WDT_TIMEOUT(64)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(rst_bc), .bus(if_c.slave));

  function automatic void push_a(int c, logic [2:0] rn, logic b, logic [1:0] cs);
    exp_t e;
    e.cyc = c; e.rn = {1'b0, rn}; e.busy = b; e.cause = cs;
    sb_a.push_back(e);
  endfunction

  // Step negedges until instance A's outputs differ from the last snapshot.
  task automatic wait_change_a(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= limit; k++) begin
      if (if_a.resetn_out !== last_rn || if_a.busy !== last_busy ||
          if_a.reset_cause !== last_cause) begin
        last_rn    = if_a.resetn_out;
        last_busy  = if_a.busy;
        last_cause = if_a.reset_cause;
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_bc = 1'b0;
    if_a.sw_reset_req = 0; if_a.wdt_en = 0; if_a.wdt_kick = 0;
    if_b.sw_reset_req = 0; if_b.wdt_en = 0; if_b.wdt_kick = 0;
    if_c.sw_reset_req = 0; if_c.wdt_en = 0; if_c.wdt_kick = 0;
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if ({if_a.resetn_out, if_a.busy, if_a.reset_cause} !== 6'b000_1_00) begin
      n_err++;
      $display("FAIL reset_a: got %b want 000_1_00",
               {if_a.resetn_out, if_a.busy, if_a.reset_cause});
    end
    n_cmp++;
    if ({if_b.resetn_out, if_b.busy, if_b.reset_cause} !== 4'b0_1_00) begin
      n_err++;
      $display("FAIL reset_b: got %b want 0_1_00",
               {if_b.resetn_out, if_b.busy, if_b.reset_cause});
    end
    n_cmp++;
    if ({if_c.resetn_out, if_c.busy, if_c.reset_cause} !== 7'b0000_1_00) begin
      n_err++;
      $display("FAIL reset_c: got %b want 0000_1_00",
               {if_c.resetn_out, if_c.busy, if_c.reset_cause});
    end
    last_rn = 3'b000; last_busy = 1'b1; last_cause = 2'b00;
  endtask

  task automatic test_power_on();
    int n; exp_t e; bit ok;
    n = cyc;
    rst_a = 1'b1;
    push_a(n + 19, 3'b001, 1'b1, 2'b00);
    push_a(n + 27, 3'b011, 1'b1, 2'b00);
    push_a(n + 35, 3'b111, 1'b0, 2'b00);
    while (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      wait_change_a(200, ok);
      n_cmp++;
      if (!ok || cyc != e.cyc || {last_rn, last_busy, last_cause} !== {e.rn[2:0], e.busy, e.cause}) begin
        n_err++;
        $display("FAIL power_on: got ok=%0d cyc=%0d out=%b, want cyc=%0d out=%b",
                 ok, cyc, {last_rn, last_busy, last_cause}, e.cyc, {e.rn[2:0], e.busy, e.cause});
      end
    end
  endtask

  task automatic test_pin_glitch();
    int n; exp_t e; bit ok;
    rst_a = 1'b0;
    #1;
    n_cmp++;
    if ({if_a.resetn_out, if_a.busy, if_a.reset_cause} !== 6'b000_1_00) begin
      n_err++;
      $display("FAIL pin_assert_async: got %b want 000_1_00",
               {if_a.resetn_out, if_a.busy, if_a.reset_cause});
    end
    last_rn = 3'b000; last_busy = 1'b1; last_cause = 2'b00;
    repeat (2) @(negedge sys_clk);
    n = cyc;
    rst_a = 1'b1;
    push_a(n + 19, 3'b001, 1'b1, 2'b00);
    for (int pass = 0; pass < 2; pass++) begin
      while (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        wait_change_a(200, ok);
        n_cmp++;
        if (!ok || cyc != e.cyc || {last_rn, last_busy, last_cause} !== {e.rn[2:0], e.busy, e.cause}) begin
          n_err++;
          $display("FAIL pin_glitch: got ok=%0d cyc=%0d out=%b, want cyc=%0d out=%b",
                   ok, cyc, {last_rn, last_busy, last_cause}, e.cyc, {e.rn[2:0], e.busy, e.cause});
        end
      end
      if (pass == 0) begin
        // 1 ns glitch while in RELEASE, just after bit 0 came up.
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if ({if_a.resetn_out, if_a.busy} !== 4'b000_1) begin
          n_err++;
          $display("FAIL glitch_async: got %b want 000_1", {if_a.resetn_out, if_a.busy});
        end
        rst_a = 1'b1;
        last_rn = 3'b000; last_busy = 1'b1; last_cause = 2'b00;
        n = cyc;
        push_a(n + 19, 3'b001, 1'b1, 2'b00);
        push_a(n + 27, 3'b011, 1'b1, 2'b00);
        push_a(n + 35, 3'b111, 1'b0, 2'b00);
      end
    end
  endtask

  task automatic test_sw_reset();
    int n; exp_t e; bit ok;
    n = cyc;
    if_a.sw_reset_req = 1'b1;
    @(negedge sys_clk);
    if_a.sw_reset_req = 1'b0;
    // A second request while in HOLD must be ignored.
    fork
      begin
        repeat (5) @(negedge sys_clk);
        if_a.sw_reset_req = 1'b1;
        @(negedge sys_clk);
        if_a.sw_reset_req = 1'b0;
      end
    join_none
    push_a(n + 1,  3'b000, 1'b1, 2'b01);
    push_a(n + 17, 3'b001, 1'b1, 2'b01);
    push_a(n + 25, 3'b011, 1'b1, 2'b01);
    push_a(n + 33, 3'b111, 1'b0, 2'b01);
    while (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      wait_change_a(200, ok);
      n_cmp++;
      if (!ok || cyc != e.cyc || {last_rn, last_busy, last_cause} !== {e.rn[2:0], e.busy, e.cause}) begin
        n_err++;
        $display("FAIL sw_reset: got ok=%0d cyc=%0d out=%b, want cyc=%0d out=%b",
                 ok, cyc, {last_rn, last_busy, last_cause}, e.cyc, {e.rn[2:0], e.busy, e.cause});
      end
    end
  endtask

  task automatic test_watchdog();
    int n; exp_t e; bit ok;
    n = cyc;
    if_a.wdt_en = 1'b1;
    push_a(n + 64,  3'b000, 1'b1, 2'b10);
    push_a(n + 80,  3'b001, 1'b1, 2'b10);
    push_a(n + 88,  3'b011, 1'b1, 2'b10);
    push_a(n + 96,  3'b111, 1'b0, 2'b10);
    push_a(n + 160, 3'b000, 1'b1, 2'b10);
    for (int pass = 0; pass < 2; pass++) begin
      while (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        wait_change_a(200, ok);
        n_cmp++;
        if (!ok || cyc != e.cyc || {last_rn, last_busy, last_cause} !== {e.rn[2:0], e.busy, e.cause}) begin
          n_err++;
          $display("FAIL wdt_expire: got ok=%0d cyc=%0d out=%b, want cyc=%0d out=%b",
                   ok, cyc, {last_rn, last_busy, last_cause}, e.cyc, {e.rn[2:0], e.busy, e.cause});
        end
      end
      if (pass == 0) begin
        if_a.wdt_en = 1'b0;
        n = cyc;
        push_a(n + 16, 3'b001, 1'b1, 2'b10);
        push_a(n + 24, 3'b011, 1'b1, 2'b10);
        push_a(n + 32, 3'b111, 1'b0, 2'b10);
      end
    end
    // Regular kicks every 60 cycles keep the watchdog from expiring.
    kick_done = 1'b0;
    if_a.wdt_en = 1'b1;
    fork
      begin
        repeat (17) begin
          repeat (59) @(negedge sys_clk);
          if_a.wdt_kick = 1'b1;
          @(negedge sys_clk);
          if_a.wdt_kick = 1'b0;
        end
        kick_done = 1'b1;
      end
    join_none
    wait_change_a(1000, ok);
    n_cmp++;
    if (ok) begin
      n_err++;
      $display("FAIL wdt_kicked: output changed at cyc=%0d to %b, want no change",
               cyc, {last_rn, last_busy, last_cause});
    end
    wait (kick_done);
    if_a.wdt_en = 1'b0;
  endtask

  task automatic test_priority();
    int n; exp_t e; bit ok;
    for (int sc = 0; sc < 3; sc++) begin
      n = cyc;
      if_a.wdt_en = 1'b1;
      if (sc == 0) begin
        // Kick lands in the expiry cycle: counter restarts instead.
        repeat (63) @(negedge sys_clk);
        if_a.wdt_kick = 1'b1;
        @(negedge sys_clk);
        if_a.wdt_kick = 1'b0;
        n = n + 64;
        push_a(n + 64, 3'b000, 1'b1, 2'b10);
        n = n + 64;
      end else if (sc == 1) begin
        // Software request and expiry together: software wins.
        repeat (63) @(negedge sys_clk);
        if_a.sw_reset_req = 1'b1;
        @(negedge sys_clk);
        if_a.sw_reset_req = 1'b0;
        if_a.wdt_en = 1'b0;
        n = n + 64;
        push_a(n, 3'b000, 1'b1, 2'b01);
      end else begin
        // 30 counts, frozen for 100 cycles, then 34 more edges to expire.
        repeat (30) @(negedge sys_clk);
        if_a.wdt_en = 1'b0;
        wait_change_a(100, ok);
        n_cmp++;
        if (ok) begin
          n_err++;
          $display("FAIL wdt_frozen: output changed at cyc=%0d to %b, want no change",
                   cyc, {last_rn, last_busy, last_cause});
        end
        n = cyc;
        if_a.wdt_en = 1'b1;
        n = n + 34;
        push_a(n, 3'b000, 1'b1, 2'b10);
      end
      push_a(n + 16, 3'b001, 1'b1, (sc == 1) ? 2'b01 : 2'b10);
      push_a(n + 24, 3'b011, 1'b1, (sc == 1) ? 2'b01 : 2'b10);
      push_a(n + 32, 3'b111, 1'b0, (sc == 1) ? 2'b01 : 2'b10);
      while (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        wait_change_a(200, ok);
        if (e.rn[2:0] == 3'b000) if_a.wdt_en = 1'b0;
        n_cmp++;
        if (!ok || cyc != e.cyc || {last_rn, last_busy, last_cause} !== {e.rn[2:0], e.busy, e.cause}) begin
          n_err++;
          $display("FAIL priority_%0d: got ok=%0d cyc=%0d out=%b, want cyc=%0d out=%b",
                   sc, ok, cyc, {last_rn, last_busy, last_cause}, e.cyc, {e.rn[2:0], e.busy, e.cause});
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    int n; exp_t e;
    n = cyc;
    rst_bc = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      e.cyc = n + k; e.cause = 2'b00;
      e.rn = {3'b000, (k >= 19)};
      e.busy = (k < 19);
      sb_b.push_back(e);
      for (int i = 0; i < 4; i++) e.rn[i] = (k >= 4 + 8 * i);
      e.busy = (k < 28);
      sb_c.push_back(e);
    end
    while (sb_b.size() > 0 && sb_c.size() > 0) begin
      @(negedge sys_clk);
      e = sb_b.pop_front();
      n_cmp++;
      if ($isunknown({if_b.resetn_out, if_b.busy, if_b.reset_cause}) ||
          {if_b.resetn_out, if_b.busy, if_b.reset_cause} !== {e.rn[0], e.busy, e.cause}) begin
        n_err++;
        $display("FAIL sweep_n1: cyc=%0d got %b want %b", cyc,
                 {if_b.resetn_out, if_b.busy, if_b.reset_cause}, {e.rn[0], e.busy, e.cause});
      end
      e = sb_c.pop_front();
      n_cmp++;
      if ($isunknown({if_c.resetn_out, if_c.busy, if_c.reset_cause}) ||
          {if_c.resetn_out, if_c.busy, if_c.reset_cause} !== {e.rn, e.busy, e.cause}) begin
        n_err++;
        $display("FAIL sweep_n4: cyc=%0d got %b want %b", cyc,
                 {if_c.resetn_out, if_c.busy, if_c.reset_cause}, {e.rn, e.busy, e.cause});
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_pin_glitch();
    test_sw_reset();
    test_watchdog();
    test_priority();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
